hbm_stream_addr_gen: RTL and testbench
======================================

HBM_STREAM_ADDR_GEN -- requirements
Module: hbm_stream_addr_gen

Interface
REQ-001 SHALL have parameter NUM_CHNL, default 8: number of independent AXI read channels driven.
REQ-002 SHALL have parameter ADDR_WIDTH, default 33: AXI address width; bit 32 selects the HBM stack.
REQ-003 SHALL have parameter ID_WIDTH, default 5: AXI ID width.
REQ-004 SHALL have parameter MAX_OUTSTANDING, default 8, range 1..15: maximum in-flight bursts per channel.
REQ-005 SHALL have ports, in this order:
- clk  in  1  sole clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse; samples cfg_* and starts a job; ignored while busy=1.
- abort  in  1  one-cycle pulse; stops issue of new bursts.
- cfg_init_addr  in  ADDR_WIDTH  channel-0 base address.
- cfg_chnl_offset  in  ADDR_WIDTH  address offset between adjacent channels.
- cfg_stride  in  32  address step between consecutive bursts.
- cfg_ops  in  32  bursts per pass per channel.
- cfg_burst_len  in  8  AXI arlen (beats-1).
- cfg_repeat  in  16  pass count; 0 is treated as 1.
- m_arvalid  out  NUM_CHNL  per-channel AR valid.
- m_arready  in  NUM_CHNL  per-channel AR ready.
- m_araddr  out  NUM_CHNL*ADDR_WIDTH  per-channel address; channel c in slice c.
- m_arlen  out  NUM_CHNL*8  per-channel burst length.
- m_arid  out  NUM_CHNL*ID_WIDTH  per-channel ID, constant c.
- m_rlast_hs  in  NUM_CHNL  one-cycle pulse per completed burst (rvalid&rready&rlast).
- busy  out  1  job active.
- done  out  1  one-cycle completion pulse.
- aborted  out  1  qualifies done; 1 when the job ended by abort.

Function
REQ-006 SHALL implement global FSM IDLE->ISSUE->DRAIN->IDLE; start in IDLE goes to ISSUE on the next edge with busy=1.
REQ-007 SHALL, on start, load per channel c: addr=cfg_init_addr+c*cfg_chnl_offset (mod 2^ADDR_WIDTH), op_cnt=0, pass_cnt=0, and latch cfg_stride, cfg_ops, cfg_burst_len and cfg_repeat.
REQ-008 Channel c SHALL assert m_arvalid[c] in ISSUE while it has bursts remaining and outstanding[c]<MAX_OUTSTANDING; a burst is issued on m_arvalid[c]&m_arready[c].
REQ-009 SHALL hold m_araddr, m_arlen and m_arvalid stable while m_arvalid=1 and m_arready=0; valid SHALL NOT drop without a handshake except on abort or rst.
REQ-010 SHALL, on each handshake, add cfg_stride to addr (wrap mod 2^ADDR_WIDTH) and increment op_cnt.
REQ-011 SHALL, when op_cnt reaches cfg_ops, increment pass_cnt, clear op_cnt, and reload addr with the channel base; the channel is finished when pass_cnt equals the effective repeat count.
REQ-012 outstanding[c] SHALL increment on handshake, decrement on m_rlast_hs[c], and hold when both occur in the same cycle; a return at outstanding=0 SHALL be ignored.
REQ-013 Back-to-back issue SHALL be supported: one burst per channel per cycle at full throughput, with zero bubbles between bursts.
REQ-014 SHALL leave ISSUE for DRAIN when all channels are finished; SHALL leave DRAIN for IDLE when all outstanding counters are 0, pulsing done for one cycle with busy=0 in the same cycle.
REQ-015 cfg_ops=0 SHALL issue no bursts; done SHALL pulse 2 cycles after start.
REQ-016 abort in ISSUE SHALL deassert all m_arvalid on the next cycle and move to DRAIN; done then pulses with aborted=1. abort in IDLE or DRAIN SHALL be ignored, except that abort in DRAIN still sets aborted=1.
REQ-017 Channels SHALL advance independently; back-pressure on one channel SHALL NOT stall the others.

Reset
REQ-018 rst SHALL force IDLE and clear every counter; outputs SHALL be m_arvalid=0, m_araddr=0, m_arlen=0, busy=0, done=0 and aborted=0, with m_arid held at its constant value.
REQ-019 rst mid-job SHALL drop all valids in the same edge with no done pulse; subsequent m_rlast_hs SHALL be ignored.

Structure
REQ-020 SHALL place FSM state encoding, the 4 KB/AXI length constants and the default parameters in shared package hbm_pkg.
REQ-021 SHALL instantiate NUM_CHNL copies of sub-module hbm_chnl_addr_gen, one per channel, each holding addr, op_cnt, pass_cnt and outstanding; the top holds the FSM and done logic.

Verification
REQ-022 NUM_CHNL=2, init=0x1000, offset=0x100000, stride=0x40, ops=3, repeat=1, arready=1 -> ch0 addresses 0x1000, 0x1040, 0x1080; ch1 addresses 0x101000, 0x101040, 0x101080; done 1 cycle after the last rlast.
REQ-023 ops=2, repeat=3 -> each channel issues 6 bursts with address pattern base, base+stride repeated 3 times.
REQ-024 MAX_OUTSTANDING=2, rlast withheld -> exactly 2 handshakes per channel, then arvalid stays low until a return occurs.
REQ-025 Simultaneous handshake and rlast on the same channel -> outstanding unchanged, verified by assertion.
REQ-026 Abort after 1 burst with 1 outstanding -> arvalid=0 next cycle; done and aborted both pulse 1 cycle after the rlast.
REQ-027 init=0x1_FFFF_FFC0, stride=0x40, ops=2 -> second address 0x0_0000_0000; rst mid-job -> all outputs at reset values and no done pulse.

Source files
------------

// File: rtl/hbm_pkg.sv
// Shared definitions for the HBM streaming read address generator:
// FSM encoding, AXI length/4 KB constants and default parameters.
package hbm_pkg;

  localparam int HBM_NUM_CHNL_DEF   = 8;
  localparam int HBM_ADDR_WIDTH_DEF = 33;
  localparam int HBM_ID_WIDTH_DEF   = 5;
  localparam int HBM_MAX_OUTST_DEF  = 8;

  localparam int AXI_4KB_BYTES = 4096;
  localparam int AXI_4KB_BITS  = 12;
  localparam int AXI_LEN_WIDTH = 8;
  localparam int AXI_MAX_LEN   = 255;

  // Wide enough for the largest legal MAX_OUTSTANDING of 15.
  localparam int OUTST_WIDTH = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2
  } gen_state_e;

  function automatic logic [15:0] eff_repeat(input logic [15:0] rep);
    return (rep == 16'd0) ? 16'd1 : rep;
  endfunction

endpackage

// File: rtl/hbm_chnl_addr_gen.sv
// One AXI read channel: walks addresses by stride for a number of passes and
// tracks in-flight bursts so issue is throttled at MAX_OUTSTANDING.
module hbm_chnl_addr_gen
  import hbm_pkg::*;
#(
  parameter int ADDR_WIDTH      = HBM_ADDR_WIDTH_DEF,
  parameter int MAX_OUTSTANDING = HBM_MAX_OUTST_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic                  issue_en,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [31:0]           stride,
  input  logic [31:0]           ops,
  input  logic [15:0]           pass_total,
  input  logic                  arready,
  input  logic                  rlast_hs,
  output logic                  arvalid,
  output logic [ADDR_WIDTH-1:0] araddr,
  output logic                  finished,
  output logic                  drained_next
);

  logic [ADDR_WIDTH-1:0]  base_q, base_d;
  logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
  logic [31:0]            op_cnt_q, op_cnt_d;
  logic [15:0]            pass_cnt_q, pass_cnt_d;
  logic [OUTST_WIDTH-1:0] outst_q, outst_d;
  logic                   hs;
  logic                   ret;

  // Valid depends only on flops, so it cannot drop while stalled unless the FSM leaves ISSUE.
  assign finished     = (ops == 32'd0) || (pass_cnt_q == pass_total);
  assign arvalid      = issue_en && !finished && (outst_q < OUTST_WIDTH'(MAX_OUTSTANDING));
  assign araddr       = addr_q;
  assign hs           = arvalid && arready;
  assign ret          = rlast_hs && (outst_q != '0);
  assign drained_next = (outst_d == '0);

  always_comb begin
    base_d     = base_q;
    addr_d     = addr_q;
    op_cnt_d   = op_cnt_q;
    pass_cnt_d = pass_cnt_q;
    outst_d    = outst_q;
    if (load) begin
      base_d     = base_addr;
      addr_d     = base_addr;
      op_cnt_d   = '0;
      pass_cnt_d = '0;
    end else if (hs) begin
      if (op_cnt_q + 32'd1 == ops) begin
        op_cnt_d   = '0;
        pass_cnt_d = pass_cnt_q + 16'd1;
        addr_d     = base_q;
      end else begin
        op_cnt_d = op_cnt_q + 32'd1;
        addr_d   = addr_q + ADDR_WIDTH'(stride);
      end
    end
    if (hs && !ret) begin
      outst_d = outst_q + 1'b1;
    end else if (!hs && ret) begin
      outst_d = outst_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      base_q     <= '0;
      addr_q     <= '0;
      op_cnt_q   <= '0;
      pass_cnt_q <= '0;
      outst_q    <= '0;
    end else begin
      base_q     <= base_d;
      addr_q     <= addr_d;
      op_cnt_q   <= op_cnt_d;
      pass_cnt_q <= pass_cnt_d;
      outst_q    <= outst_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && hs && rlast_hs && (outst_q != '0)) begin
      assert (outst_d == outst_q);
    end
  end

endmodule

// File: rtl/hbm_stream_addr_gen.sv
// Multi-channel HBM read address generator: global IDLE/ISSUE/DRAIN control,
// latched job configuration and the done/aborted completion pulse.
module hbm_stream_addr_gen
  import hbm_pkg::*;
#(
  parameter int NUM_CHNL        = HBM_NUM_CHNL_DEF,
  parameter int ADDR_WIDTH      = HBM_ADDR_WIDTH_DEF,
  parameter int ID_WIDTH        = HBM_ID_WIDTH_DEF,
  parameter int MAX_OUTSTANDING = HBM_MAX_OUTST_DEF
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  input  logic                           abort,
  input  logic [ADDR_WIDTH-1:0]          cfg_init_addr,
  input  logic [ADDR_WIDTH-1:0]          cfg_chnl_offset,
  input  logic [31:0]                    cfg_stride,
  input  logic [31:0]                    cfg_ops,
  input  logic [AXI_LEN_WIDTH-1:0]       cfg_burst_len,
  input  logic [15:0]                    cfg_repeat,
  output logic [NUM_CHNL-1:0]            m_arvalid,
  input  logic [NUM_CHNL-1:0]            m_arready,
  output logic [NUM_CHNL*ADDR_WIDTH-1:0] m_araddr,
  output logic [NUM_CHNL*8-1:0]          m_arlen,
  output logic [NUM_CHNL*ID_WIDTH-1:0]   m_arid,
  input  logic [NUM_CHNL-1:0]            m_rlast_hs,
  output logic                           busy,
  output logic                           done,
  output logic                           aborted
);

  gen_state_e               state_q, state_d;
  logic [31:0]              stride_q, stride_d;
  logic [31:0]              ops_q, ops_d;
  logic [AXI_LEN_WIDTH-1:0] len_q, len_d;
  logic [15:0]              pass_total_q, pass_total_d;
  logic                     abort_flag_q, abort_flag_d;
  logic                     busy_q, busy_d;
  logic                     done_q, done_d;
  logic                     aborted_q, aborted_d;
  logic                     load;
  logic [NUM_CHNL-1:0]      chnl_finished;
  logic [NUM_CHNL-1:0]      chnl_drained;

  assign busy    = busy_q;
  assign done    = done_q;
  assign aborted = aborted_q;

  // DRAIN is skipped when nothing is in flight, so an empty job completes two cycles after start.
  always_comb begin
    state_d      = state_q;
    stride_d     = stride_q;
    ops_d        = ops_q;
    len_d        = len_q;
    pass_total_d = pass_total_q;
    abort_flag_d = abort_flag_q;
    done_d       = 1'b0;
    aborted_d    = 1'b0;
    load         = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          load         = 1'b1;
          state_d      = ST_ISSUE;
          stride_d     = cfg_stride;
          ops_d        = cfg_ops;
          len_d        = cfg_burst_len;
          pass_total_d = eff_repeat(cfg_repeat);
          abort_flag_d = 1'b0;
        end
      end
      ST_ISSUE: begin
        if (abort) begin
          abort_flag_d = 1'b1;
          state_d      = ST_DRAIN;
        end else if (&chnl_finished) begin
          if (&chnl_drained) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end else begin
            state_d = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        if (abort) begin
          abort_flag_d = 1'b1;
        end
        if (&chnl_drained) begin
          state_d   = ST_IDLE;
          done_d    = 1'b1;
          aborted_d = abort_flag_d;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      stride_q     <= '0;
      ops_q        <= '0;
      len_q        <= '0;
      pass_total_q <= '0;
      abort_flag_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      aborted_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      stride_q     <= stride_d;
      ops_q        <= ops_d;
      len_q        <= len_d;
      pass_total_q <= pass_total_d;
      abort_flag_q <= abort_flag_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      aborted_q    <= aborted_d;
    end
  end

  for (genvar c = 0; c < NUM_CHNL; c++) begin : g_chnl
    hbm_chnl_addr_gen #(
      .ADDR_WIDTH     (ADDR_WIDTH),
      .MAX_OUTSTANDING(MAX_OUTSTANDING)
    ) u_chnl (
      .clk         (clk),
      .rst         (rst),
      .load        (load),
      .issue_en    (state_q == ST_ISSUE),
      .base_addr   (cfg_init_addr + ADDR_WIDTH'(c) * cfg_chnl_offset),
      .stride      (stride_q),
      .ops         (ops_q),
      .pass_total  (pass_total_q),
      .arready     (m_arready[c]),
      .rlast_hs    (m_rlast_hs[c]),
      .arvalid     (m_arvalid[c]),
      .araddr      (m_araddr[c*ADDR_WIDTH +: ADDR_WIDTH]),
      .finished    (chnl_finished[c]),
      .drained_next(chnl_drained[c])
    );
    assign m_arlen[c*8 +: 8]              = len_q;
    assign m_arid[c*ID_WIDTH +: ID_WIDTH] = ID_WIDTH'(c);
  end

endmodule

// File: tb/tb_hbm_stream_addr_gen.sv
// Scoreboard bench for hbm_stream_addr_gen: expected addresses are queued per
// channel when a job is configured and popped as each AR handshake is seen.
module tb_hbm_stream_addr_gen;

  localparam int NC = 2;
  localparam int AW = 33;
  localparam int IW = 5;
  localparam int MO = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic              abort;
  logic [AW-1:0]     cfg_init_addr;
  logic [AW-1:0]     cfg_chnl_offset;
  logic [31:0]       cfg_stride;
  logic [31:0]       cfg_ops;
  logic [7:0]        cfg_burst_len;
  logic [15:0]       cfg_repeat;
  logic [NC-1:0]     m_arvalid;
  logic [NC-1:0]     m_arready;
  logic [NC*AW-1:0]  m_araddr;
  logic [NC*8-1:0]   m_arlen;
  logic [NC*IW-1:0]  m_arid;
  logic [NC-1:0]     m_rlast_hs = '0;
  logic              busy;
  logic              done;
  logic              aborted;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  logic [AW-1:0] exp_q0[$];
  logic [AW-1:0] exp_q1[$];
  logic [7:0]    exp_len = '0;

  int hs_cnt[NC];
  int ret_cnt[NC];
  bit resp_en   = 1'b0;
  bit stall_chk = 1'b0;
  bit rdy_rand  = 1'b0;
  int done_cnt  = 0;
  int done_cyc  = 0;
  bit done_ab   = 1'b0;
  int rlast_cyc = 0;
  int start_cyc = 0;
  bit            prev_stall[NC];
  logic [AW-1:0] prev_addr[NC];

  hbm_stream_addr_gen #(
    .NUM_CHNL       (NC),
    .ADDR_WIDTH     (AW),
    .ID_WIDTH       (IW),
    .MAX_OUTSTANDING(MO)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .abort          (abort),
    .cfg_init_addr  (cfg_init_addr),
    .cfg_chnl_offset(cfg_chnl_offset),
    .cfg_stride     (cfg_stride),
    .cfg_ops        (cfg_ops),
    .cfg_burst_len  (cfg_burst_len),
    .cfg_repeat     (cfg_repeat),
    .m_arvalid      (m_arvalid),
    .m_arready      (m_arready),
    .m_araddr       (m_araddr),
    .m_arlen        (m_arlen),
    .m_arid         (m_arid),
    .m_rlast_hs     (m_rlast_hs),
    .busy           (busy),
    .done           (done),
    .aborted        (aborted)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic void push_exp(input int c, input logic [AW-1:0] a);
    if (c == 0) exp_q0.push_back(a);
    else        exp_q1.push_back(a);
  endfunction

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
      if (rdy_rand) m_arready = NC'($urandom);
    end
  endtask

  // Closed-form address model: base + op*stride for every pass.
  task automatic applyStimulus(input logic [AW-1:0] init, input logic [AW-1:0] off,
                               input logic [31:0] stride, input logic [31:0] ops,
                               input logic [7:0] len, input logic [15:0] rep, input bit push);
    logic [AW-1:0] base;
    int passes;
    cfg_init_addr   = init;
    cfg_chnl_offset = off;
    cfg_stride      = stride;
    cfg_ops         = ops;
    cfg_burst_len   = len;
    cfg_repeat      = rep;
    exp_len         = len;
    passes          = (rep == 16'd0) ? 1 : int'(rep);
    if (push) begin
      for (int c = 0; c < NC; c++) begin
        base = init + AW'(c) * off;
        for (int p = 0; p < passes; p++)
          for (int o = 0; o < int'(ops); o++)
            push_exp(c, base + AW'(o) * AW'(stride));
      end
    end
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input int max_cyc);
    int d0;
    int k;
    d0 = done_cnt;
    k  = 0;
    while (done_cnt == d0 && k < max_cyc) begin
      tick();
      k++;
    end
    checkOutput("done within bound", 64'(done_cnt != d0), 64'd1);
  endtask

  // Return one burst per cycle per channel for every handshake seen so far.
  always @(posedge clk) begin
    #2;
    for (int c = 0; c < NC; c++) begin
      if (resp_en && !rst && hs_cnt[c] > ret_cnt[c]) begin
        m_rlast_hs[c] = 1'b1;
        ret_cnt[c]++;
      end else begin
        m_rlast_hs[c] = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    logic [AW-1:0] got;
    logic [AW-1:0] exp;
    bit have;
    if (!rst) begin
      for (int c = 0; c < NC; c++) begin
        got = m_araddr[c*AW +: AW];
        if (stall_chk && prev_stall[c]) begin
          checkOutput($sformatf("ch%0d valid held", c), 64'(m_arvalid[c]), 64'd1);
          checkOutput($sformatf("ch%0d addr held", c), 64'(got), 64'(prev_addr[c]));
        end
        if (m_arvalid[c] && m_arready[c]) begin
          hs_cnt[c]++;
          have = (c == 0) ? (exp_q0.size() > 0) : (exp_q1.size() > 0);
          checkOutput($sformatf("ch%0d burst expected", c), 64'(have), 64'd1);
          if (have) begin
            exp = (c == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
            checkOutput($sformatf("ch%0d araddr", c), 64'(got), 64'(exp));
          end
          checkOutput($sformatf("ch%0d arlen", c), 64'(m_arlen[c*8 +: 8]), 64'(exp_len));
          checkOutput($sformatf("ch%0d arid", c), 64'(m_arid[c*IW +: IW]), 64'(c));
        end
        prev_stall[c] = m_arvalid[c] && !m_arready[c];
        prev_addr[c]  = got;
      end
      if (|m_rlast_hs) rlast_cyc = cyc;
      if (start && !busy) start_cyc = cyc;
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
        done_ab  = aborted;
        checkOutput("busy low with done", 64'(busy), 64'd0);
      end
    end else begin
      for (int c = 0; c < NC; c++) prev_stall[c] = 1'b0;
    end
  end

  initial begin
    int h0[NC];
    int d0;
    rst             = 1'b1;
    start           = 1'b0;
    abort           = 1'b0;
    cfg_init_addr   = '0;
    cfg_chnl_offset = '0;
    cfg_stride      = '0;
    cfg_ops         = '0;
    cfg_burst_len   = '0;
    cfg_repeat      = '0;
    m_arready       = '0;
    for (int c = 0; c < NC; c++) begin
      hs_cnt[c]     = 0;
      ret_cnt[c]    = 0;
      prev_stall[c] = 1'b0;
      prev_addr[c]  = '0;
    end
    tick(3);

    checkOutput("reset arvalid", 64'(m_arvalid), 64'd0);
    checkOutput("reset araddr", 64'(m_araddr), 64'd0);
    checkOutput("reset arlen", 64'(m_arlen), 64'd0);
    checkOutput("reset arid", 64'(m_arid), 64'h020);
    checkOutput("reset busy", 64'(busy), 64'd0);
    checkOutput("reset done", 64'(done), 64'd0);
    checkOutput("reset aborted", 64'(aborted), 64'd0);
    rst = 1'b0;
    tick();

    $display("[TB] basic two-channel stream");
    resp_en   = 1'b1;
    stall_chk = 1'b1;
    m_arready = '1;
    for (int c = 0; c < NC; c++) h0[c] = hs_cnt[c];
    applyStimulus(33'h1000, 33'h100000, 32'h40, 32'd3, 8'd7, 16'd1, 1'b1);
    checkOutput("busy after start", 64'(busy), 64'd1);
    wait_done(100);
    checkOutput("basic aborted", 64'(done_ab), 64'd0);
    checkOutput("basic done after rlast", 64'(done_cyc - rlast_cyc), 64'd1);
    checkOutput("basic ch0 bursts", 64'(hs_cnt[0] - h0[0]), 64'd3);
    checkOutput("basic ch1 bursts", 64'(hs_cnt[1] - h0[1]), 64'd3);
    checkOutput("basic queues empty", 64'(exp_q0.size() + exp_q1.size()), 64'd0);
    checkOutput("basic busy idle", 64'(busy), 64'd0);

    $display("[TB] repeat passes with random back-pressure");
    rdy_rand = 1'b1;
    for (int c = 0; c < NC; c++) h0[c] = hs_cnt[c];
    applyStimulus(33'h20000, 33'h4000, 32'h100, 32'd2, 8'd3, 16'd3, 1'b1);
    wait_done(400);
    rdy_rand  = 1'b0;
    m_arready = '1;
    checkOutput("repeat ch0 bursts", 64'(hs_cnt[0] - h0[0]), 64'd6);
    checkOutput("repeat ch1 bursts", 64'(hs_cnt[1] - h0[1]), 64'd6);
    checkOutput("repeat queues empty", 64'(exp_q0.size() + exp_q1.size()), 64'd0);
    checkOutput("repeat aborted", 64'(done_ab), 64'd0);

    $display("[TB] outstanding limit");
    resp_en = 1'b0;
    for (int c = 0; c < NC; c++) h0[c] = hs_cnt[c];
    applyStimulus(33'h8000, 33'h1000, 32'h80, 32'd5, 8'd0, 16'd1, 1'b1);
    tick(8);
    checkOutput("limit ch0 bursts", 64'(hs_cnt[0] - h0[0]), 64'(MO));
    checkOutput("limit ch1 bursts", 64'(hs_cnt[1] - h0[1]), 64'(MO));
    checkOutput("limit arvalid low", 64'(m_arvalid), 64'd0);
    resp_en = 1'b1;
    wait_done(100);
    checkOutput("limit ch0 total", 64'(hs_cnt[0] - h0[0]), 64'd5);
    checkOutput("limit queues empty", 64'(exp_q0.size() + exp_q1.size()), 64'd0);

    $display("[TB] abort with one burst outstanding");
    resp_en   = 1'b0;
    stall_chk = 1'b0;
    m_arready = '0;
    for (int c = 0; c < NC; c++) h0[c] = hs_cnt[c];
    push_exp(0, 33'h40000);
    push_exp(1, 33'h40800);
    applyStimulus(33'h40000, 33'h800, 32'h40, 32'd4, 8'd1, 16'd1, 1'b0);
    m_arready = '1;
    tick();
    m_arready = '0;
    abort     = 1'b1;
    tick();
    abort = 1'b0;
    checkOutput("abort arvalid low", 64'(m_arvalid), 64'd0);
    checkOutput("abort still busy", 64'(busy), 64'd1);
    checkOutput("abort ch0 bursts", 64'(hs_cnt[0] - h0[0]), 64'd1);
    d0 = done_cnt;
    tick(3);
    checkOutput("abort waits for return", 64'(done_cnt - d0), 64'd0);
    resp_en = 1'b1;
    wait_done(20);
    checkOutput("abort aborted flag", 64'(done_ab), 64'd1);
    checkOutput("abort done after rlast", 64'(done_cyc - rlast_cyc), 64'd1);
    d0    = done_cnt;
    abort = 1'b1;
    tick();
    abort = 1'b0;
    tick(2);
    checkOutput("idle abort ignored", 64'(done_cnt - d0), 64'd0);
    checkOutput("idle abort busy", 64'(busy), 64'd0);

    $display("[TB] zero ops job");
    stall_chk = 1'b1;
    m_arready = '1;
    for (int c = 0; c < NC; c++) h0[c] = hs_cnt[c];
    applyStimulus(33'h100, 33'h10, 32'h40, 32'd0, 8'd0, 16'd5, 1'b1);
    wait_done(10);
    checkOutput("zero ops latency", 64'(done_cyc - start_cyc), 64'd2);
    checkOutput("zero ops bursts", 64'(hs_cnt[0] + hs_cnt[1] - h0[0] - h0[1]), 64'd0);
    checkOutput("zero ops aborted", 64'(done_ab), 64'd0);

    $display("[TB] 33-bit address wrap");
    applyStimulus(33'h1_FFFF_FFC0, 33'h200, 32'h40, 32'd2, 8'd15, 16'd0, 1'b1);
    wait_done(50);
    checkOutput("wrap queues empty", 64'(exp_q0.size() + exp_q1.size()), 64'd0);

    $display("[TB] reset mid-job");
    stall_chk = 1'b0;
    applyStimulus(33'h0, 33'h1000, 32'h40, 32'd100, 8'd3, 16'd1, 1'b1);
    tick(4);
    rst = 1'b1;
    tick();
    checkOutput("midrst arvalid", 64'(m_arvalid), 64'd0);
    checkOutput("midrst araddr", 64'(m_araddr), 64'd0);
    checkOutput("midrst arlen", 64'(m_arlen), 64'd0);
    checkOutput("midrst busy", 64'(busy), 64'd0);
    checkOutput("midrst done", 64'(done), 64'd0);
    checkOutput("midrst aborted", 64'(aborted), 64'd0);
    rst = 1'b0;
    d0  = done_cnt;
    tick(10);
    checkOutput("midrst no done", 64'(done_cnt - d0), 64'd0);
    checkOutput("midrst stays idle", 64'(m_arvalid), 64'd0);
    exp_q0.delete();
    exp_q1.delete();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
